regfile_rename: RTL and testbench

- Architectural register file with per-register rename tags. Sits directly downstream of the reorder buffer (ROB).
- Accepts in-order commit writes from the ROB (name, data, ROB tag) and clears a register's pending tag only when the committing tag matches the one recorded.
- Serves the decoder each cycle:
  - two source lookups returning either committed data or the producing ROB tag;
  - one destination rename that records the tag of the newly issued instruction.

---
 rtl/regfile_rename_pkg.sv | 33 +++
 rtl/regfile_rename_lookup.sv | 40 ++++
 rtl/regfile_rename.sv | 98 +++++++++
 tb/tb_regfile_rename.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_rename_pkg.sv
// regfile_rename_pkg: constants and helpers shared by the rename register file,
// the ROB and the decoder.
//   DATA_W / REG_W / TAG_W : data, register-index and tag widths
//   TAG_FREE               : tag value meaning "no pending producer"
//   ROB_IDX_HI/LO          : slice of a tag holding the ROB index
package regfile_rename_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_W      = 5;
   localparam int unsigned TAG_W      = 4;
   localparam int unsigned NUM_REGS   = 1 << REG_W;
   localparam int unsigned CNT_W      = REG_W + 1;
   localparam int unsigned ROB_IDX_HI = TAG_W - 2;
   localparam int unsigned ROB_IDX_LO = 0;

   // MSB set, ROB index cleared
   localparam logic [TAG_W-1:0] TAG_FREE = TAG_W'(1) << (ROB_IDX_HI + 1);

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [TAG_W-1:0]  tag_t;
   typedef logic [REG_W-1:0]  reg_t;

   // Register has an in-flight producer
   function automatic logic tag_busy(input logic [TAG_W-1:0] t);
      return t != TAG_FREE;
   endfunction

   // ROB entry index carried by a tag
   function automatic logic [ROB_IDX_HI:ROB_IDX_LO] rob_idx(input logic [TAG_W-1:0] t);
      return t[ROB_IDX_HI:ROB_IDX_LO];
   endfunction

endpackage

// File: rtl/regfile_rename_lookup.sv
// regfile_rename_lookup: one combinational source read port.
// Masks register 0 to data 0 / TAG_FREE. With REGFILE_COMMIT_BYPASS_EN defined,
// a matching commit in the same cycle is forwarded (data = commit_data, tag free).
//   src_reg            : register index being looked up
//   reg_data / reg_tag : stored state of that register
//   commit_*           : ROB commit port (bypass build only)
//   src_data / src_tag : lookup result
module regfile_rename_lookup
   import regfile_rename_pkg::*;
(
   input  logic [REG_W-1:0]  src_reg,
   input  logic [DATA_W-1:0] reg_data,
   input  logic [TAG_W-1:0]  reg_tag,
`ifdef REGFILE_COMMIT_BYPASS_EN
   input  logic              commit_en,
   input  logic [REG_W-1:0]  commit_reg,
   input  logic [DATA_W-1:0] commit_data,
   input  logic [TAG_W-1:0]  commit_tag,
`endif
   output logic [DATA_W-1:0] src_data,
   output logic [TAG_W-1:0]  src_tag
);

   always_comb begin
      src_data = reg_data;
      src_tag  = reg_tag;
      if (src_reg == '0) begin
         src_data = '0;
         src_tag  = TAG_FREE;
      end
`ifdef REGFILE_COMMIT_BYPASS_EN
      // Forward a commit that retires this register's current producer
      else if (commit_en && (commit_reg == src_reg) && (reg_tag == commit_tag)) begin
         src_data = commit_data;
         src_tag  = TAG_FREE;
      end
`endif
   end

endmodule

// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with per-register rename tags.
// Optional same-cycle commit forwarding on the read ports: REGFILE_COMMIT_BYPASS_EN.
//   clk, rst (sync, active-low)
//   rename_en/reg/tag : destination rename from the decoder
//   src1_*/src2_*     : combinational source lookups (data or producing tag)
//   commit_en/reg/data/tag : in-order commit write from the ROB
//   flush             : discard all pending renames
//   busy_cnt          : registered count of registers with a pending tag
module regfile_rename
   import regfile_rename_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rename_en,
   input  logic [REG_W-1:0]  rename_reg,
   input  logic [TAG_W-1:0]  rename_tag,
   input  logic [REG_W-1:0]  src1_reg,
   input  logic [REG_W-1:0]  src2_reg,
   output logic [DATA_W-1:0] src1_data,
   output logic [TAG_W-1:0]  src1_tag,
   output logic [DATA_W-1:0] src2_data,
   output logic [TAG_W-1:0]  src2_tag,
   input  logic              commit_en,
   input  logic [REG_W-1:0]  commit_reg,
   input  logic [DATA_W-1:0] commit_data,
   input  logic [TAG_W-1:0]  commit_tag,
   input  logic              flush,
   output logic [CNT_W-1:0]  busy_cnt
);

   data_t data_q [NUM_REGS];
   tag_t  tag_q  [NUM_REGS];

   logic rename_ok;
   logic commit_ok;
   logic commit_clr;
   logic cnt_inc;
   logic cnt_dec;

   // Qualify writes and derive the busy counter delta
   always_comb begin
      rename_ok  = rename_en && (rename_reg != '0);
      commit_ok  = commit_en && (commit_reg != '0);
      // A same-register rename overrides the commit's tag clear
      commit_clr = commit_ok && (tag_q[commit_reg] == commit_tag)
                   && !(rename_ok && (rename_reg == commit_reg));
      cnt_inc    = rename_ok && !tag_busy(tag_q[rename_reg]);
      cnt_dec    = commit_clr && tag_busy(tag_q[commit_reg]);
   end

   // State update: commit data always lands; flush drops tags and renames
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q   <= '{default: '0};
         tag_q    <= '{default: TAG_FREE};
         busy_cnt <= '0;
      end else begin
         if (commit_ok) data_q[commit_reg] <= commit_data;
         if (flush) begin
            tag_q    <= '{default: TAG_FREE};
            busy_cnt <= '0;
         end else begin
            if (commit_clr) tag_q[commit_reg] <= TAG_FREE;
            if (rename_ok)  tag_q[rename_reg] <= rename_tag;
            busy_cnt <= busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
         end
      end
   end

   regfile_rename_lookup u_src1 (
      .src_reg     (src1_reg),
      .reg_data    (data_q[src1_reg]),
      .reg_tag     (tag_q[src1_reg]),
`ifdef REGFILE_COMMIT_BYPASS_EN
      .commit_en   (commit_en),
      .commit_reg  (commit_reg),
      .commit_data (commit_data),
      .commit_tag  (commit_tag),
`endif
      .src_data    (src1_data),
      .src_tag     (src1_tag)
   );

   regfile_rename_lookup u_src2 (
      .src_reg     (src2_reg),
      .reg_data    (data_q[src2_reg]),
      .reg_tag     (tag_q[src2_reg]),
`ifdef REGFILE_COMMIT_BYPASS_EN
      .commit_en   (commit_en),
      .commit_reg  (commit_reg),
      .commit_data (commit_data),
      .commit_tag  (commit_tag),
`endif
      .src_data    (src2_data),
      .src_tag     (src2_tag)
   );

endmodule

// File: tb/tb_regfile_rename.sv
// tb_regfile_rename: directed stimulus with a scoreboard queue; a negedge monitor
// pops each expected record and compares it with the DUT outputs of that cycle.
module tb_regfile_rename;

   localparam logic [3:0] TF = 4'h8;

   logic        clk = 1'b0;
   logic        rst;
   logic        rename_en;
   logic [4:0]  rename_reg;
   logic [3:0]  rename_tag;
   logic [4:0]  src1_reg;
   logic [4:0]  src2_reg;
   logic [31:0] src1_data;
   logic [3:0]  src1_tag;
   logic [31:0] src2_data;
   logic [3:0]  src2_tag;
   logic        commit_en;
   logic [4:0]  commit_reg;
   logic [31:0] commit_data;
   logic [3:0]  commit_tag;
   logic        flush;
   logic [5:0]  busy_cnt;

   typedef struct {
      string       label;
      logic [31:0] d1;
      logic [3:0]  t1;
      logic [31:0] d2;
      logic [3:0]  t2;
      logic [5:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   regfile_rename dut (
      .clk         (clk),
      .rst         (rst),
      .rename_en   (rename_en),
      .rename_reg  (rename_reg),
      .rename_tag  (rename_tag),
      .src1_reg    (src1_reg),
      .src2_reg    (src2_reg),
      .src1_data   (src1_data),
      .src1_tag    (src1_tag),
      .src2_data   (src2_data),
      .src2_tag    (src2_tag),
      .commit_en   (commit_en),
      .commit_reg  (commit_reg),
      .commit_data (commit_data),
      .commit_tag  (commit_tag),
      .flush       (flush),
      .busy_cnt    (busy_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // Monitor: compare every cycle that has an expectation queued
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk({e.label, ".src1_data"}, src1_data, e.d1);
         chk({e.label, ".src1_tag"},  32'(src1_tag),  32'(e.t1));
         chk({e.label, ".src2_data"}, src2_data, e.d2);
         chk({e.label, ".src2_tag"},  32'(src2_tag),  32'(e.t2));
         chk({e.label, ".busy_cnt"},  32'(busy_cnt),  32'(e.cnt));
      end
   end

   task automatic drive(input logic ren, input logic [4:0] rr, input logic [3:0] rt,
                        input logic cen, input logic [4:0] cr, input logic [31:0] cd,
                        input logic [3:0] ct, input logic fl,
                        input logic [4:0] s1, input logic [4:0] s2);
      rename_en = ren; rename_reg = rr; rename_tag = rt;
      commit_en = cen; commit_reg = cr; commit_data = cd; commit_tag = ct;
      flush = fl; src1_reg = s1; src2_reg = s2;
   endtask

   task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
      drive(1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, s1, s2);
   endtask

   task automatic push(input string l, input logic [31:0] d1, input logic [3:0] t1,
                       input logic [31:0] d2, input logic [3:0] t2, input logic [5:0] c);
      exp_t e;
      e.label = l; e.d1 = d1; e.t1 = t1; e.d2 = d2; e.t2 = t2; e.cnt = c;
      exp_q.push_back(e);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      idle(5'd0, 5'd0);
      tick; tick;

      // Reset state
      rst = 1'b1;
      idle(5'd5, 5'd0);                 push("reset", 0, TF, 0, TF, 0);  tick;

      // Rename r3 tag 2: not visible in the same cycle
      drive(1, 3, 2, 0, 0, 0, 0, 0, 3, 0); push("ren_same_cycle", 0, TF, 0, TF, 0); tick;
      idle(5'd3, 5'd0);                 push("ren_r3", 0, 4'd2, 0, TF, 1); tick;

      // Matching commit clears the tag
      drive(0, 0, 0, 1, 3, 32'hDEADBEEF, 2, 0, 5, 0); push("commit_cyc", 0, TF, 0, TF, 1); tick;
      idle(5'd3, 5'd0);                 push("commit_match", 32'hDEADBEEF, TF, 0, TF, 0); tick;

      // Stale commit keeps the younger tag
      drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0); push("ren_r4_t1_cyc", 0, TF, 0, TF, 0); tick;
      drive(1, 4, 5, 0, 0, 0, 0, 0, 4, 0); push("ren_r4_t1", 0, 4'd1, 0, TF, 1); tick;
      drive(0, 0, 0, 1, 4, 32'd7, 1, 0, 0, 0); push("rerename_cnt", 0, TF, 0, TF, 1); tick;
      idle(5'd4, 5'd0);                 push("stale_commit", 32'd7, 4'd5, 0, TF, 1); tick;

      // Commit and rename on r6 in the same cycle
      drive(1, 6, 3, 0, 0, 0, 0, 0, 0, 0); push("ren_r6_cyc", 0, TF, 0, TF, 1); tick;
      drive(1, 6, 4, 1, 6, 32'h66, 3, 0, 0, 6); push("cr_same_cyc", 0, TF, 0, 4'd3, 2); tick;
      idle(5'd6, 5'd0);                 push("commit_rename_same", 32'h66, 4'd4, 0, TF, 2); tick;

      // Register 0 ignores rename and commit
      drive(1, 0, 2, 1, 0, 32'd9, 0, 0, 0, 0); push("r0_cyc", 0, TF, 0, TF, 2); tick;
      idle(5'd0, 5'd0);                 push("r0_ignored", 0, TF, 0, TF, 2); tick;

      // Flush with a simultaneous commit and rename
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); push("ren_r1", 0, TF, 0, TF, 2); tick;
      drive(1, 2, 7, 0, 0, 0, 0, 0, 1, 0); push("ren_r2", 0, 4'd1, 0, TF, 3); tick;
      drive(1, 5, 2, 1, 1, 32'h11, 1, 1, 2, 0); push("flush_cyc", 0, 4'd7, 0, TF, 4); tick;
      idle(5'd1, 5'd5);                 push("flush", 32'h11, TF, 0, TF, 0); tick;
      idle(5'd4, 5'd6);                 push("flush_tags", 32'd7, TF, 32'h66, TF, 0); tick;

      // Commit bypass on src2
      drive(1, 7, 6, 0, 0, 0, 0, 0, 0, 0); push("ren_r7", 0, TF, 0, TF, 0); tick;
      drive(0, 0, 0, 1, 7, 32'h55, 6, 0, 0, 7);
`ifdef REGFILE_COMMIT_BYPASS_EN
      push("bypass_same", 0, TF, 32'h55, TF, 1);
`else
      push("bypass_same", 0, TF, 0, 4'd6, 1);
`endif
      tick;
      idle(5'd0, 5'd7);                 push("bypass_after", 0, TF, 32'h55, TF, 0); tick;

      // Fill every register: counter saturates at 31 by construction
      for (int r = 1; r < 32; r++) begin
         drive(1, 5'(r), 4'(r % 8), 0, 0, 0, 0, 0, 0, 0);
         tick;
      end
      idle(5'd9, 5'd31);                push("all_busy", 0, 4'd1, 0, 4'd7, 31); tick;
      drive(1, 5, 3, 0, 0, 0, 0, 0, 0, 0); push("rerename_full_cyc", 0, TF, 0, TF, 31); tick;
      idle(5'd5, 5'd0);                 push("rerename_full", 0, 4'd3, 0, TF, 31); tick;

      // Reset overrides a same-cycle rename
      rst = 1'b0;
      drive(1, 3, 3, 1, 2, 32'hAA, 7, 0, 0, 0); push("rst_cyc", 0, TF, 0, TF, 31); tick;
      rst = 1'b1;
      idle(5'd3, 5'd1);                 push("reset_override", 0, TF, 0, TF, 0); tick;
      idle(5'd0, 5'd0);
      tick;

      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
